// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake on input and output
//
// Purpose:
//   Eight legacy single-cycle operations plus SRA, SLT, iterative unsigned
//   multiply (shift-add) and unsigned restoring divide. Results are registered
//   and held until the consumer takes them.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operands/op presented
//   in_ready     block can accept an operation (IDLE only)
//   SrcA, SrcB   operands
//   ALUControl   4-bit opcode
//   shamt        shift amount for SLL/SRL/SRA (shifts SrcB)
//   out_valid    result available (DONE)
//   out_ready    consumer takes the result
//   ALUResult    result / MULU low word / DIVU quotient
//   ALUResultHi  MULU high word / DIVU remainder / 0 otherwise
//   Zero         ALUResult == 0
//   Err          DIVU by zero or illegal opcode

module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     SrcA,
    input  logic [WIDTH-1:0]     SrcB,
    input  logic [3:0]           ALUControl,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     ALUResult,
    output logic [WIDTH-1:0]     ALUResultHi,
    output logic                 Zero,
    output logic                 Err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    // Iteration working registers: r_hi is the product high word / partial
    // remainder, r_lo is the multiplier / dividend shifting into the quotient.
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_res_hi;
    logic               r_zero;
    logic               r_err;

    logic [WIDTH-1:0]   w_alu;
    logic               w_illegal;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;

    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;

    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;

    // Single-cycle operations, evaluated straight from the inputs so the
    // result can be registered on the accept edge.
    always_comb begin
        w_alu     = '0;
        w_illegal = 1'b0;
        case (ALUControl)
            OP_AND:  w_alu = SrcA & SrcB;
            OP_OR:   w_alu = SrcA | SrcB;
            OP_ADD:  w_alu = SrcA + SrcB;
            OP_XOR:  w_alu = SrcA ^ SrcB;
            OP_SLL:  w_alu = SrcB << shamt;
            OP_SRL:  w_alu = SrcB >> shamt;
            OP_SUB:  w_alu = SrcA - SrcB;
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SRA:  w_alu = $signed(SrcB) >>> shamt;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_MULU: w_alu = '0;
            OP_DIVU: w_alu = '0;
            default: w_illegal = 1'b1;
        endcase
    end

    // Shift-add multiply step: conditionally add the multiplicand into the
    // high word, then shift the whole {carry, hi, lo} right by one.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder, subtract the divisor only if it fits. The difference fits
    // in WIDTH bits whenever the subtraction is taken.
    always_comb begin
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_rem   = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_b) : w_div_shift[WIDTH-1:0];
        w_div_quo   = {r_lo[WIDTH-2:0], w_div_ge};
    end

    always_comb begin
        w_next_hi = r_is_div ? w_div_rem : w_mul_hi;
        w_next_lo = r_is_div ? w_div_quo : w_mul_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_b         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_res_hi    <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (ALUControl == OP_MULU ||
                            (ALUControl == OP_DIVU && SrcB != '0)) begin
                            r_hi     <= '0;
                            r_lo     <= SrcA;
                            r_b      <= SrcB;
                            r_is_div <= (ALUControl == OP_DIVU);
                            r_cnt    <= CNT_W'(WIDTH);
                            r_state  <= S_BUSY;
                        end else if (ALUControl == OP_DIVU) begin
                            // Divide by zero short-circuits: no iterations.
                            r_res       <= '1;
                            r_res_hi    <= SrcA;
                            r_zero      <= 1'b0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            // Illegal opcodes fall out with w_alu = 0, so Zero=1.
                            r_res       <= w_alu;
                            r_res_hi    <= '0;
                            r_zero      <= (w_alu == '0);
                            r_err       <= w_illegal;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt - 1'b1;
                    // Last iteration loads the outputs directly so out_valid
                    // rises on the edge the counter reaches zero.
                    if (r_cnt == CNT_W'(1)) begin
                        r_res       <= w_next_lo;
                        r_res_hi    <= w_next_hi;
                        r_zero      <= (w_next_lo == '0);
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_zero      <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign ALUResult   = r_res;
    assign ALUResultHi = r_res_hi;
    assign Zero        = r_zero;
    assign Err         = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard testbench for alu_seq

module tb_alu_seq;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   SrcA;
    logic [W-1:0]   SrcB;
    logic [3:0]     ALUControl;
    logic [4:0]     shamt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   ALUResult;
    logic [W-1:0]   ALUResultHi;
    logic           Zero;
    logic           Err;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .ALUControl  (ALUControl),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .ALUResultHi (ALUResultHi),
        .Zero        (Zero),
        .Err         (Err)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        e;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    logic prev_ov = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: on each rising out_valid, pop the oldest expectation and compare.
    always @(posedge clk) begin
        #1;
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_res"},  64'(ALUResult),   64'(e.res));
                chk({e.name, "_hi"},   64'(ALUResultHi), 64'(e.hi));
                chk({e.name, "_zero"}, 64'(Zero),        64'(e.z));
                chk({e.name, "_err"},  64'(Err),         64'(e.e));
                chk({e.name, "_lat"},  64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
        prev_ov = out_valid;
    end

    // Drive one operation, wait (bounded) for acceptance; the expectation is
    // queued before the accept edge with the cycle number that edge produces.
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic ez, input logic ee, input int el);
        exp_t e;
        bit   done;
        done = 0;
        @(negedge clk);
        SrcA = a; SrcB = b; ALUControl = op; shamt = sh; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                e.name = nm; e.res = er; e.hi = eh; e.z = ez; e.e = ee;
                e.lat = el; e.acc = cyc + 1;
                sb.push_back(e);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        SrcA = $urandom; SrcB = $urandom;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; ALUControl = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),    64'd1);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_res",       64'(ALUResult),   64'd0);
        chk("rst_hi",        64'(ALUResultHi), 64'd0);
        chk("rst_zero",      64'(Zero),        64'd0);
        chk("rst_err",       64'(Err),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
        issue("sub_neg",  4'b0110, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1);
        issue("and",      4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 32'h0, 1'b0, 1'b0, 1);
        issue("or",       4'b0001, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 32'h0, 1'b0, 1'b0, 1);
        issue("xor",      4'b0011, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h00000FF0, 32'h0, 1'b0, 1'b0, 1);
        issue("sll4",     4'b0100, 32'h0, 32'h1, 5'd4, 32'h00000010, 32'h0, 1'b0, 1'b0, 1);
        issue("sll0",     4'b0100, 32'h0, 32'h00001234, 5'd0, 32'h00001234, 32'h0, 1'b0, 1'b0, 1);
        issue("sra4",     4'b1000, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1);
        issue("srl4",     4'b0101, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 32'h0, 1'b0, 1'b0, 1);
        issue("sra0",     4'b1000, 32'h0, 32'h80000001, 5'd0, 32'h80000001, 32'h0, 1'b0, 1'b0, 1);
        issue("slt",      4'b1001, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 32'h0, 1'b0, 1'b0, 1);
        issue("sltu",     4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
        issue("mulu",     4'b1010, 32'hFFFFFFFF, 32'h2, 5'd0, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 33);
        issue("mulu_zero",4'b1010, 32'h0, 32'h5, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 33);
        issue("mulu_big", 4'b1010, 32'h00010001, 32'h00010001, 5'd0, 32'h00020001, 32'h00000001, 1'b0, 1'b0, 33);
        issue("divu",     4'b1011, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 1'b0, 33);
        issue("divu_big", 4'b1011, 32'hFFFFFFFF, 32'h10, 5'd0, 32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 33);
        issue("divu_zero",4'b1011, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 1);
        issue("ill_1111", 4'b1111, 32'h12345678, 32'h9, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        issue("ill_1100", 4'b1100, 32'h1, 32'h1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        drain();

        // Backpressure: result held, held request accepted after handoff.
        out_ready = 1'b0;
        issue("bp_add", 4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 32'h0, 1'b0, 1'b0, 1);
        fork
            issue("bp_xor", 4'b0011, 32'h0000000F, 32'h000000F0, 5'd0, 32'h000000FF, 32'h0, 1'b0, 1'b0, 1);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready",  64'(in_ready),  64'd0);
                    chk("bp_out_valid", 64'(out_valid), 64'd1);
                    chk("bp_res_hold",  64'(ALUResult), 64'd7);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("bp_idle_in_ready",  64'(in_ready),  64'd1);
                chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
                @(posedge clk);
                #1;
                chk("bp_next_out_valid", 64'(out_valid), 64'd1);
                chk("bp_next_res",       64'(ALUResult), 64'h000000FF);
            end
        join
        drain();

        // Reset mid-MULU: everything must return to the reset state.
        issue("rst_mulu", 4'b1010, 32'h7, 32'h9, 5'd0, 32'd63, 32'h0, 1'b0, 1'b0, 33);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_res",       64'(ALUResult), 64'd0);
        chk("midrst_err",       64'(Err),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("post_rst_add", 4'b0010, 32'd10, 32'd20, 5'd0, 32'd30, 32'h0, 1'b0, 1'b0, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
